// File: rtl/switch_debouncer.sv
// Debounces a bouncy asynchronous switch. The new level is accepted only after
// STABLE_CYCLES consecutive synchronized samples; one-cycle edge strobes and a press counter are also provided.
module switch_debouncer #(
    parameter int STABLE_CYCLES = 500000,
    parameter int CNT_W         = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sw_in,
    output logic       db_level,
    output logic       rise_pulse,
    output logic       fall_pulse,
    output logic [7:0] press_count
);

    localparam logic [1:0] S_LOW       = 2'd0;
    localparam logic [1:0] S_WAIT_HIGH = 2'd1;
    localparam logic [1:0] S_HIGH      = 2'd2;
    localparam logic [1:0] S_WAIT_LOW  = 2'd3;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync1;
    logic             sync2;
    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             go_high;
    logic             go_low;

    // sync2 is the only copy of the switch the FSM is allowed to look at.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        go_high    = 1'b0;
        go_low     = 1'b0;
        case (state)
            S_LOW: begin
                if (sync2) begin
                    state_next = S_WAIT_HIGH;
                    cnt_next   = CNT_ONE;
                end else begin
                    cnt_next = '0;
                end
            end
            S_WAIT_HIGH: begin
                if (!sync2) begin
                    state_next = S_LOW;
                    cnt_next   = '0;
                end else if (cnt >= CNT_LAST) begin
                    state_next = S_HIGH;
                    cnt_next   = '0;
                    go_high    = 1'b1;
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end
            S_HIGH: begin
                if (!sync2) begin
                    state_next = S_WAIT_LOW;
                    cnt_next   = CNT_ONE;
                end else begin
                    cnt_next = '0;
                end
            end
            S_WAIT_LOW: begin
                if (sync2) begin
                    state_next = S_HIGH;
                    cnt_next   = '0;
                end else if (cnt >= CNT_LAST) begin
                    state_next = S_LOW;
                    cnt_next   = '0;
                    go_low     = 1'b1;
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end
            default: begin
                state_next = S_LOW;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1       <= 1'b0;
            sync2       <= 1'b0;
            state       <= S_LOW;
            cnt         <= '0;
            db_level    <= 1'b0;
            rise_pulse  <= 1'b0;
            fall_pulse  <= 1'b0;
            press_count <= 8'd0;
        end else begin
            sync1      <= sw_in;
            sync2      <= sync1;
            state      <= state_next;
            cnt        <= cnt_next;
            rise_pulse <= go_high;
            fall_pulse <= go_low;
            // Outputs update on the same edge as the accepting transition.
            if (go_high) begin
                db_level    <= 1'b1;
                press_count <= press_count + 8'd1;
            end else if (go_low) begin
                db_level <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_switch_debouncer.sv
// Bench for switch_debouncer: directed scenarios plus random switch activity,
// compared each cycle against a sample-history reference model.
module tb_switch_debouncer;

    localparam int SC = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       sw_in;
    logic       db_level;
    logic       rise_pulse;
    logic       fall_pulse;
    logic [7:0] press_count;

    int tests = 0;
    int fails = 0;
    int rise_seen = 0;
    int fall_seen = 0;

    // Reference model: level flips once the last SC synchronized samples all differ from it.
    logic       m_s1, m_s2, m_level, m_rise, m_fall;
    logic [7:0] m_count;
    logic       hist[$];

    switch_debouncer #(.STABLE_CYCLES(SC), .CNT_W(4)) dut (
        .clk(clk),
        .rst(rst),
        .sw_in(sw_in),
        .db_level(db_level),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse),
        .press_count(press_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_level = 0; m_rise = 0; m_fall = 0; m_count = 0;
        hist.delete();
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_db"},    32'(db_level),    32'd0);
        check({tag, "_rise"},  32'(rise_pulse),  32'd0);
        check({tag, "_fall"},  32'(fall_pulse),  32'd0);
        check({tag, "_count"}, 32'(press_count), 32'd0);
    endtask

    task automatic tick();
        logic s_cur;
        bit   all_diff;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            s_cur = m_s2;
            m_s2  = m_s1;
            m_s1  = sw_in;
            hist.push_back(s_cur);
            if (hist.size() > SC) void'(hist.pop_front());
            m_rise = 0;
            m_fall = 0;
            all_diff = (hist.size() == SC);
            foreach (hist[i]) if (hist[i] == m_level) all_diff = 0;
            if (all_diff) begin
                m_level = ~m_level;
                if (m_level) begin
                    m_rise = 1;
                    m_count++;
                end else begin
                    m_fall = 1;
                end
            end
        end
        #1;
        check("model_db",    32'(db_level),    32'(m_level));
        check("model_rise",  32'(rise_pulse),  32'(m_rise));
        check("model_fall",  32'(fall_pulse),  32'(m_fall));
        check("model_count", 32'(press_count), 32'(m_count));
        check("rise_and_fall", 32'(rise_pulse & fall_pulse), 32'd0);
        if (rise_pulse) rise_seen++;
        if (fall_pulse) fall_seen++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        repeat (2) tick();
        rst = 1'b0;
    endtask

    initial begin
        int r0, f0;
        logic [7:0] c0;
        rst   = 1'b1;
        sw_in = 1'b0;
        model_reset();
        #2;
        check_zero_outputs("reset_init");
        repeat (2) tick();
        rst = 1'b0;
        repeat (3) tick();

        // Bounce from low: must not be accepted.
        r0 = rise_seen; c0 = press_count;
        sw_in = 1; tick(); sw_in = 0; tick(); sw_in = 1; tick(); sw_in = 0; tick();
        repeat (8) tick();
        check("bounce_db",    32'(db_level),    32'd0);
        check("bounce_count", 32'(press_count), 32'(c0));
        check("bounce_rise",  32'(rise_seen),   32'(r0));

        // Clean press: sw_in changes before edge k, accepted at edge k+5.
        sw_in = 1;
        repeat (5) tick();
        check("press_k4_db", 32'(db_level), 32'd0);
        tick();
        check("press_k5_db",    32'(db_level),    32'd1);
        check("press_k5_rise",  32'(rise_pulse),  32'd1);
        check("press_k5_count", 32'(press_count), 32'd1);
        tick();
        check("press_k6_rise", 32'(rise_pulse), 32'd0);

        // Long hold yields no further pulses.
        r0 = rise_seen;
        repeat (100) tick();
        check("hold_db",   32'(db_level),  32'd1);
        check("hold_rise", 32'(rise_seen), 32'(r0));

        // Release.
        r0 = rise_seen;
        sw_in = 0;
        repeat (5) tick();
        check("release_k4_db", 32'(db_level), 32'd1);
        tick();
        check("release_k5_db",   32'(db_level),   32'd0);
        check("release_k5_fall", 32'(fall_pulse), 32'd1);
        check("release_rise",    32'(rise_seen),  32'(r0));
        repeat (4) tick();

        // Reset in the middle of a wait, asserted between clock edges.
        sw_in = 1;
        repeat (3) tick();
        #2 rst = 1'b1;
        model_reset();
        #1;
        check_zero_outputs("reset_midwait");
        repeat (2) tick();
        rst = 1'b0;
        r0 = rise_seen;
        repeat (5) tick();
        check("post_rst_k4_db", 32'(db_level), 32'd0);
        tick();
        check("post_rst_k5_db",    32'(db_level),    32'd1);
        check("post_rst_k5_count", 32'(press_count), 32'd1);
        check("post_rst_rise",     32'(rise_seen),   32'(r0 + 1));

        // Reset while high, between edges.
        #3 rst = 1'b1;
        model_reset();
        #1;
        check_zero_outputs("reset_high");
        repeat (2) tick();
        sw_in = 0;
        rst = 1'b0;
        repeat (4) tick();

        // Counter wrap after 256 presses.
        do_reset();
        r0 = rise_seen; f0 = fall_seen;
        for (int i = 0; i < 256; i++) begin
            sw_in = 1; repeat (7) tick();
            sw_in = 0; repeat (7) tick();
        end
        check("wrap_count", 32'(press_count),      32'd0);
        check("wrap_rises", 32'(rise_seen - r0),   32'd256);
        check("wrap_falls", 32'(fall_seen - f0),   32'd256);

        // Random activity with occasional asynchronous resets.
        for (int i = 0; i < 1500; i++) begin
            sw_in = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 7)) tick();
            if ($urandom_range(0, 49) == 0) begin
                #3 rst = 1'b1;
                model_reset();
                #1;
                check_zero_outputs("reset_rand");
                tick();
                rst = 1'b0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
